// File: rtl/decoder_pkg.sv
// Shared definitions for the one-hot decoder family.
//
// Contents:
//   MODE_DIRECT / MODE_SCAN : values of the decoder 'mode' input
//   DIR_UP / DIR_DOWN       : values of the scan 'dir' input
//   onehot(sel, width)      : one-hot vector with bit 'sel' set, all zero when
//                             sel falls outside 0..width-1. The result is
//                             ONEHOT_MAX_W wide; callers cast it down to
//                             their own output width.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int unsigned ONEHOT_MAX_W = 256;

  // A select beyond the requested width decodes to nothing rather than
  // wrapping, so a mis-sized caller sees an idle output instead of a
  // wrong strobe.
  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [7:0] sel,
                                                     input int unsigned width);
    logic [ONEHOT_MAX_W-1:0] result;
    result = ONEHOT_MAX_W'(1) << sel;
    if (32'(sel) >= width) begin
      result = '0;
    end
    return result;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Free-running slot timer: counts 0..DWELL-1 while 'run' is high and
// flags the terminal count so the owner can advance to its next slot.
//
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, count <= 0
//   run   : advance the count this cycle
//   clear : force the count back to 0 (wins over run)
//   tick  : combinational, high while run=1 and the count is DWELL-1;
//           the count returns to 0 on that same edge
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // With DWELL=1 the terminal count is 0, so tick is high on every
  // running cycle and the count simply stays at 0.
  always_comb begin
    tick  = run && (cnt_q == TERMINAL);
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register; holds whenever neither run nor clear is asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// SEL_W-to-2^SEL_W one-hot decoder with registered outputs, enable,
// selectable polarity and an auto-scan mode that walks the outputs.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   en   : 1 = decode/scan active, 0 = outputs inactive and state frozen
//   mode : MODE_DIRECT decodes 'in', MODE_SCAN decodes the internal index
//   dir  : scan direction, DIR_UP or DIR_DOWN
//   load : scan mode only, idx <= in and the dwell restarts
//   in   : select input
//   out  : registered one-hot (one-cold when ACTIVE_LOW=1) decode of idx
//   idx  : index currently decoded on out
//   wrap : one-cycle pulse registered together with a wrapped idx
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b0,
  localparam int OUT_W     = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [SEL_W-1:0] in,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  // XOR mask that turns a one-hot decode into the requested polarity;
  // it is also the all-inactive output pattern.
  localparam logic [OUT_W-1:0] INACTIVE = ACTIVE_LOW ? '1 : '0;

  logic [SEL_W-1:0] idx_q;
  logic [SEL_W-1:0] idx_d;
  logic [OUT_W-1:0] out_q;
  logic [OUT_W-1:0] out_d;
  logic             wrap_q;
  logic             wrap_d;

  logic timerRun;
  logic timerClear;
  logic timerTick;

  // The dwell count only moves while scanning; direct mode and load pin
  // it at 0 so a later scan always starts with a full dwell. With en=0
  // neither control is asserted, which freezes the count.
  always_comb begin
    timerRun   = en && (mode == MODE_SCAN) && !load;
    timerClear = en && ((mode == MODE_DIRECT) || load);
  end

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk   (clk),
    .rst   (rst),
    .run   (timerRun),
    .clear (timerClear),
    .tick  (timerTick)
  );

  // Next index and wrap flag. Load shares the direct-mode path, so it
  // overrides a step that would have happened on the same edge. Index
  // arithmetic is modulo OUT_W through natural SEL_W-bit overflow.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (en) begin
      if ((mode == MODE_DIRECT) || load) begin
        idx_d = in;
      end else if (timerTick) begin
        if (dir == DIR_DOWN) begin
          idx_d  = idx_q - SEL_W'(1);
          wrap_d = (idx_q == '0);
        end else begin
          idx_d  = idx_q + SEL_W'(1);
          wrap_d = (idx_q == '1);
        end
      end
    end
  end

  // The output decodes the index being registered on the same edge, so
  // out and idx can never disagree.
  always_comb begin
    out_d = INACTIVE;
    if (en) begin
      out_d = OUT_W'(onehot(8'(idx_d), OUT_W)) ^ INACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      out_q  <= INACTIVE;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan. Three instances share the same
// stimulus: DWELL=2 active-high, DWELL=2 active-low and DWELL=1
// active-high. A slot-level model (integer index, dwell count, modular
// stepping with overflow detection) predicts every instance each cycle,
// and a set of hand-computed literal expectations pins the model.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mode;
  logic       dir;
  logic       load;
  logic [2:0] in;

  logic [7:0] out0,    outLow,  outFast;
  logic [2:0] idx0,    idxLow,  idxFast;
  logic       wrap0,   wrapLow, wrapFast;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(3), .DWELL(2), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .in(in), .out(out0), .idx(idx0), .wrap(wrap0)
  );

  decoder_scan #(.SEL_W(3), .DWELL(2), .ACTIVE_LOW(1'b1)) dutLow (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .in(in), .out(outLow), .idx(idxLow), .wrap(wrapLow)
  );

  decoder_scan #(.SEL_W(3), .DWELL(1), .ACTIVE_LOW(1'b0)) dutFast (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .in(in), .out(outFast), .idx(idxFast), .wrap(wrapFast)
  );

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change on the falling edge so they are stable at the next
  // rising edge.
  task automatic applyStimulus(input logic r, input logic e, input logic m,
                               input logic d, input logic l, input logic [2:0] v);
    @(negedge clk);
    rst  = r;
    en   = e;
    mode = m;
    dir  = d;
    load = l;
    in   = v;
  endtask

  task automatic waitEdge();
    @(posedge clk);
    #2;
  endtask

  // Slot-level reference model, one entry per instance.
  int  mIdx[3];
  int  mCnt[3];
  bit  mWrap[3];
  bit  mActive[3];
  int  dwellOf[3] = '{2, 2, 1};
  bit  modelValid = 1'b0;

  always @(posedge clk) begin
    int nextIdx;
    logic [7:0] expOut, aOut;
    logic [2:0] aIdx;
    logic       aWrap;
    for (int k = 0; k < 3; k++) begin
      mWrap[k] = 1'b0;
      if (rst) begin
        mIdx[k] = 0;
        mCnt[k] = 0;
        mActive[k] = 1'b0;
      end else if (!en) begin
        mActive[k] = 1'b0;
      end else if (mode == 1'b0 || load) begin
        mIdx[k] = int'(in);
        mCnt[k] = 0;
        mActive[k] = 1'b1;
      end else begin
        mActive[k] = 1'b1;
        if (mCnt[k] == dwellOf[k] - 1) begin
          mCnt[k] = 0;
          nextIdx = dir ? mIdx[k] - 1 : mIdx[k] + 1;
          if (nextIdx < 0) begin
            nextIdx = nextIdx + 8;
            mWrap[k] = 1'b1;
          end else if (nextIdx > 7) begin
            nextIdx = nextIdx - 8;
            mWrap[k] = 1'b1;
          end
          mIdx[k] = nextIdx;
        end else begin
          mCnt[k] = mCnt[k] + 1;
        end
      end
    end
    if (rst) modelValid = 1'b1;
    #1;
    if (modelValid) begin
      for (int k = 0; k < 3; k++) begin
        expOut = mActive[k] ? 8'(1 << mIdx[k]) : 8'h00;
        if (k == 1) expOut = ~expOut;
        case (k)
          0:       begin aOut = out0;    aIdx = idx0;    aWrap = wrap0;    end
          1:       begin aOut = outLow;  aIdx = idxLow;  aWrap = wrapLow;  end
          default: begin aOut = outFast; aIdx = idxFast; aWrap = wrapFast; end
        endcase
        checkOutput($sformatf("model out[%0d]", k), aOut, expOut);
        checkOutput($sformatf("model idx[%0d]", k), {5'b0, aIdx}, 8'(mIdx[k]));
        checkOutput($sformatf("model wrap[%0d]", k), {7'b0, aWrap}, {7'b0, mWrap[k]});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; in = 3'd0;

    // Reset for two cycles
    applyStimulus(1, 0, 0, 0, 0, 0); waitEdge();
    applyStimulus(1, 0, 0, 0, 0, 0); waitEdge();
    checkOutput("reset out",     out0,         8'h00);
    checkOutput("reset outLow",  outLow,       8'hFF);
    checkOutput("reset idx",     {5'b0, idx0}, 8'h00);
    checkOutput("reset wrap",    {7'b0, wrap0}, 8'h00);

    // Direct decode of every select value
    for (int v = 0; v < 8; v++) begin
      applyStimulus(0, 1, 0, 0, 0, 3'(v)); waitEdge();
      if (v == 0) checkOutput("direct in=0", out0, 8'h01);
      if (v == 3) checkOutput("direct in=3", out0, 8'h08);
    end
    checkOutput("direct in=7",     out0,         8'h80);
    checkOutput("direct idx=7",    {5'b0, idx0}, 8'h07);

    // Disable: outputs idle, index held
    applyStimulus(0, 0, 0, 0, 0, 5); waitEdge();
    checkOutput("disabled out",    out0,         8'h00);
    checkOutput("disabled outLow", outLow,       8'hFF);
    checkOutput("disabled idx",    {5'b0, idx0}, 8'h07);

    applyStimulus(0, 1, 0, 0, 0, 5); waitEdge();
    checkOutput("direct in=5",     out0,   8'h20);
    checkOutput("active-low in=5", outLow, 8'hDF);

    // Scan up from 6 with DWELL=2, through the wrap
    applyStimulus(0, 1, 0, 0, 0, 6); waitEdge();
    checkOutput("scan start 6", out0, 8'h40);
    applyStimulus(0, 1, 1, 0, 0, 0); waitEdge();
    checkOutput("scan dwell 6", out0, 8'h40);
    applyStimulus(0, 1, 1, 0, 0, 0); waitEdge();
    checkOutput("scan step 7", out0, 8'h80);
    applyStimulus(0, 1, 1, 0, 0, 0); waitEdge();
    checkOutput("scan dwell 7", out0, 8'h80);
    applyStimulus(0, 1, 1, 0, 0, 0); waitEdge();
    checkOutput("scan wrap out", out0, 8'h01);
    checkOutput("scan wrap up",  {7'b0, wrap0}, 8'h01);
    applyStimulus(0, 1, 1, 0, 0, 0); waitEdge();
    checkOutput("wrap one cycle", {7'b0, wrap0}, 8'h00);

    // Scan down from 0 wraps to 7, then load on a step cycle
    applyStimulus(0, 1, 1, 1, 0, 0); waitEdge();
    checkOutput("down wrap out",  out0,          8'h80);
    checkOutput("down wrap flag", {7'b0, wrap0}, 8'h01);
    applyStimulus(0, 1, 1, 1, 0, 0); waitEdge();
    applyStimulus(0, 1, 1, 1, 1, 3); waitEdge();
    checkOutput("load idx",  {5'b0, idx0},  8'h03);
    checkOutput("load wrap", {7'b0, wrap0}, 8'h00);
    applyStimulus(0, 1, 1, 1, 0, 0); waitEdge();
    checkOutput("load dwell restarts", out0, 8'h08);
    applyStimulus(0, 1, 1, 1, 0, 0); waitEdge();
    checkOutput("down step 2", out0, 8'h04);

    // Pause mid-dwell at 4, then resume with the held dwell count
    applyStimulus(0, 1, 1, 0, 1, 4); waitEdge();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(0, 0, 1, 0, 0, 0); waitEdge();
    end
    checkOutput("paused out", out0,         8'h00);
    checkOutput("paused idx", {5'b0, idx0}, 8'h04);
    applyStimulus(0, 1, 1, 0, 0, 0); waitEdge();
    checkOutput("resume out", out0, 8'h10);
    applyStimulus(0, 1, 1, 0, 0, 0); waitEdge();
    checkOutput("resume step", out0, 8'h20);

    // Reset mid-scan at 6
    applyStimulus(0, 1, 1, 0, 1, 6); waitEdge();
    applyStimulus(0, 1, 1, 0, 0, 0); waitEdge();
    applyStimulus(1, 1, 1, 0, 0, 0); waitEdge();
    checkOutput("midscan rst out",  out0,          8'h00);
    checkOutput("midscan rst idx",  {5'b0, idx0},  8'h00);
    checkOutput("midscan rst wrap", {7'b0, wrap0}, 8'h00);
    applyStimulus(0, 1, 1, 0, 0, 0); waitEdge();
    checkOutput("post-reset scan", out0, 8'h01);

    // Direction change mid-dwell does not restart the dwell
    applyStimulus(0, 1, 1, 0, 0, 0); waitEdge();
    applyStimulus(0, 1, 1, 1, 0, 0); waitEdge();
    checkOutput("dir change dwell", out0, 8'h02);
    applyStimulus(0, 1, 1, 1, 0, 0); waitEdge();
    checkOutput("dir change step", out0, 8'h01);

    // Scan back to direct follows 'in' immediately
    applyStimulus(0, 1, 0, 1, 0, 2); waitEdge();
    checkOutput("scan to direct", out0, 8'h04);
    applyStimulus(0, 1, 0, 0, 0, 2); waitEdge();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
